// File: rtl/fifo_burst_drain_if.sv
// fifo_burst_drain_if
// Bundles the FIFO read side and the SDRAM burst-write side of fifo_burst_drain.
//   master : the drain block (drives fifo_rd and the wr_* / status outputs)
//   slave  : the FIFO + SDRAM controller environment
// Signals
//   fifo_out       FIFO read data, valid the cycle after fifo_rd
//   rd_data_count  words currently held in the FIFO
//   fifo_rd        FIFO read strobe, one word per cycle
//   wr_req         burst write request, held until wr_gnt is sampled
//   wr_addr        burst start address, stable while wr_req=1
//   wr_gnt         single-cycle grant from the SDRAM controller
//   wr_data        write data, qualified by wr_data_valid
//   wr_data_valid  high for BURST_LEN consecutive cycles per burst
//   burst_done     single-cycle pulse after the last data word
//   burst_cnt      completed bursts, wraps at 0xFFFF
//   busy           high whenever the drain FSM is not idle
// Handshake: wr_req is a request that stays asserted, with wr_addr frozen,
// until the cycle in which wr_gnt=1 is sampled; the grant is a one-cycle
// pulse and is only honoured while a request is pending.
interface fifo_burst_drain_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 24
);
    logic [DATA_W-1:0] fifo_out;
    logic [CNT_W-1:0]  rd_data_count;
    logic              fifo_rd;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_gnt;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_valid;
    logic              burst_done;
    logic [15:0]       burst_cnt;
    logic              busy;

    modport master (
        input  fifo_out, rd_data_count, wr_gnt,
        output fifo_rd, wr_req, wr_addr, wr_data, wr_data_valid,
               burst_done, burst_cnt, busy
    );

    modport slave (
        output fifo_out, rd_data_count, wr_gnt,
        input  fifo_rd, wr_req, wr_addr, wr_data, wr_data_valid,
               burst_done, burst_cnt, busy
    );
endinterface

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain
// Consumer end of the mock-data FIFO. Waits for a full burst in the FIFO,
// requests the SDRAM write port, and on grant streams BURST_LEN words out as
// one SDRAM write burst. Burst addresses advance linearly and wrap from
// ADDR_LIMIT back to ADDR_BASE.
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   enable       permits starting new bursts (a running burst always completes)
//   o_dbg_state  current FSM state (state_t encoding)
//   bus          fifo_burst_drain_if.master, FIFO read + SDRAM write signals
//   chk_err      (FIFO_BURST_DRAIN_CHECK_EN only) sticky data-pattern error
//   chk_err_cnt  (FIFO_BURST_DRAIN_CHECK_EN only) saturating error count
// Optional feature: define FIFO_BURST_DRAIN_CHECK_EN to add a checker that
// expects incrementing words on the write data stream.
module fifo_burst_drain #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 8,
    parameter int BURST_LEN  = 8,
    parameter int ADDR_W     = 24,
    parameter int ADDR_BASE  = 0,
    parameter int ADDR_LIMIT = 2**24
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    output logic [2:0]  o_dbg_state,
    fifo_burst_drain_if.master bus
`ifdef FIFO_BURST_DRAIN_CHECK_EN
    ,
    output logic        chk_err,
    output logic [15:0] chk_err_cnt
`endif
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_XFER  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One extra bit so the wrap comparison cannot overflow at the top of the space.
    localparam int AW1 = ADDR_W + 1;

    state_t            r_state;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_fifo_rd;
    logic              r_wr_req;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_burst_done;
    logic [15:0]       r_burst_cnt;
    logic              r_busy;
    logic              r_data_valid;

    logic [AW1-1:0]    w_addr_sum;
    logic [DATA_W-1:0] w_wr_data;

    assign w_addr_sum = {1'b0, r_wr_addr} + AW1'(BURST_LEN);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= S_IDLE;
            r_word_cnt   <= '0;
            r_fifo_rd    <= 1'b0;
            r_wr_req     <= 1'b0;
            r_wr_addr    <= ADDR_W'(ADDR_BASE);
            r_burst_done <= 1'b0;
            r_burst_cnt  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && (bus.rd_data_count >= CNT_W'(BURST_LEN))) begin
                        r_state  <= S_REQ;
                        r_wr_req <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_REQ: begin
                    // enable is deliberately not looked at: a raised request is never withdrawn.
                    if (bus.wr_gnt) begin
                        r_state    <= S_XFER;
                        r_wr_req   <= 1'b0;
                        r_fifo_rd  <= 1'b1;
                        r_word_cnt <= '0;
                    end
                end
                S_XFER: begin
                    if (r_word_cnt == CNT_W'(BURST_LEN - 1)) begin
                        r_state   <= S_FLUSH;
                        r_fifo_rd <= 1'b0;
                    end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Last FIFO word is on fifo_out this cycle; close out the burst.
                    r_state      <= S_DONE;
                    r_burst_done <= 1'b1;
                    r_burst_cnt  <= r_burst_cnt + 16'd1;
                    if (w_addr_sum >= AW1'(ADDR_LIMIT))
                        r_wr_addr <= ADDR_W'(ADDR_BASE);
                    else
                        r_wr_addr <= w_addr_sum[ADDR_W-1:0];
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_fifo_rd <= 1'b0;
                    r_wr_req  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // FIFO data appears the cycle after the read strobe, so the qualifier is
    // the strobe delayed by one cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_data_valid <= 1'b0;
        else      r_data_valid <= r_fifo_rd;
    end

    // The FIFO's output register already holds the word for exactly the
    // qualified cycle; forwarding it keeps the burst gap-free. Gated so the
    // bus reads zero outside a burst and during reset.
    assign w_wr_data = r_data_valid ? bus.fifo_out : '0;

    assign bus.fifo_rd       = r_fifo_rd;
    assign bus.wr_req        = r_wr_req;
    assign bus.wr_addr       = r_wr_addr;
    assign bus.wr_data       = w_wr_data;
    assign bus.wr_data_valid = r_data_valid;
    assign bus.burst_done    = r_burst_done;
    assign bus.burst_cnt     = r_burst_cnt;
    assign bus.busy          = r_busy;
    assign o_dbg_state       = r_state;

`ifdef FIFO_BURST_DRAIN_CHECK_EN
    // Incrementing-pattern checker. The first word after reset seeds it; each
    // later word is compared against the previous actual word plus one, so a
    // single glitch counts once rather than desynchronising the rest.
    logic              r_seeded;
    logic [DATA_W-1:0] r_prev;
    logic              r_chk_err;
    logic [15:0]       r_chk_err_cnt;
    logic [DATA_W-1:0] w_prev_inc;

    assign w_prev_inc = r_prev + DATA_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_seeded      <= 1'b0;
            r_prev        <= '0;
            r_chk_err     <= 1'b0;
            r_chk_err_cnt <= '0;
        end else if (r_data_valid) begin
            r_seeded <= 1'b1;
            r_prev   <= w_wr_data;
            if (r_seeded && (w_wr_data != w_prev_inc)) begin
                r_chk_err <= 1'b1;
                if (r_chk_err_cnt != 16'hFFFF)
                    r_chk_err_cnt <= r_chk_err_cnt + 16'd1;
            end
        end
    end

    assign chk_err     = r_chk_err;
    assign chk_err_cnt = r_chk_err_cnt;
`endif
endmodule

// File: tb/tb_fifo_burst_drain.sv
module tb_fifo_burst_drain;
  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [2:0] dbg_state;
`ifdef FIFO_BURST_DRAIN_CHECK_EN
  logic        chk_err;
  logic [15:0] chk_err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // FIFO model state, owned by the single stimulus process.
  logic [31:0] word_next = 32'h10;
  logic [31:0] skip_at   = 32'hFFFF_FFFF;
  int          lvl       = 5;

  fifo_burst_drain_if #(.DATA_W(32), .CNT_W(8), .ADDR_W(24)) bus();

  fifo_burst_drain #(
    .DATA_W(32), .CNT_W(8), .BURST_LEN(8), .ADDR_W(24),
    .ADDR_BASE(0), .ADDR_LIMIT(32)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .enable(enable),
    .o_dbg_state(dbg_state),
    .bus(bus)
`ifdef FIFO_BURST_DRAIN_CHECK_EN
    ,
    .chk_err(chk_err),
    .chk_err_cnt(chk_err_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: FIFO pops on a sampled read, then outputs settle before return.
  task automatic step();
    logic rd;
    rd = bus.fifo_rd;
    @(posedge clk);
    #1;
    if (rd && rst_n) begin
      bus.fifo_out = word_next;
      word_next = (word_next == skip_at) ? word_next + 32'd2 : word_next + 32'd1;
      if (lvl > 0) lvl--;
    end
    bus.rd_data_count = 8'(lvl);
    #1;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.wr_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("req_wait", ok, 1);
  endtask

  task automatic run_burst(input int gnt_dly, input logic [23:0] exp_addr,
                           input logic [31:0] first_word, input logic [15:0] exp_cnt,
                           input logic [23:0] exp_next, input bit drop_en);
    bit ok;
    int rd_n, first_rd, vld_n, first_vld, done_n, done_rel, req_early, hold_bad;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    rd_n = 0; first_rd = -1; vld_n = 0; first_vld = -1;
    done_n = 0; done_rel = -1; req_early = 0; hold_bad = 0;
    wait_req(60, ok);
    if (ok) begin
      chk("req_addr", bus.wr_addr, exp_addr);
      repeat (gnt_dly) begin
        step();
        if (bus.wr_req !== 1'b1 || bus.wr_addr !== exp_addr) hold_bad++;
      end
      chk("req_hold", hold_bad, 0);
      bus.wr_gnt = 1'b1;
      step();
      bus.wr_gnt = 1'b0;
      chk("busy_xfer", bus.busy, 1);
      for (int i = 0; i < 8; i++) exp_q.push_back(first_word + 32'(i));
      for (int rel = 0; rel < 12; rel++) begin
        if (bus.fifo_rd === 1'b1) begin
          rd_n++;
          if (first_rd < 0) first_rd = rel;
        end
        if (bus.wr_data_valid === 1'b1) begin
          vld_n++;
          if (first_vld < 0) first_vld = rel;
          if (exp_q.size() == 0) chk("data_extra", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("wr_data", bus.wr_data, e);
          end
        end
        if (bus.burst_done === 1'b1) begin
          done_n++;
          done_rel = rel;
        end
        if (rel <= 10 && bus.wr_req === 1'b1) req_early++;
        if (drop_en && rel == 2) enable = 1'b0;
        step();
      end
      chk("rd_cycles", rd_n, 8);
      chk("rd_first", first_rd, 0);
      chk("valid_cycles", vld_n, 8);
      chk("valid_first", first_vld, 1);
      chk("data_missing", exp_q.size(), 0);
      chk("done_pulses", done_n, 1);
      chk("done_latency", done_rel, 9);
      chk("no_overlap", req_early, 0);
      chk("burst_cnt", bus.burst_cnt, exp_cnt);
      chk("next_addr", bus.wr_addr, exp_next);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          gnt_dly;
    int          lvl;
    logic [23:0] addr;
    logic [31:0] word;
    logic [15:0] cnt;
    logic [23:0] next_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int n, guard, seen_req, seen_rd;

    vecs[0] = '{3,  8, 24'd0,  32'h10, 16'd1, 24'd8};
    vecs[1] = '{1, 16, 24'd8,  32'h18, 16'd2, 24'd16};
    vecs[2] = '{0, 16, 24'd16, 32'h20, 16'd3, 24'd24};
    vecs[3] = '{2, 16, 24'd24, 32'h28, 16'd4, 24'd0};
    vecs[4] = '{5, 16, 24'd0,  32'h30, 16'd5, 24'd8};

    // ---- reset ----
    rst_n = 1'b0;
    enable = 1'b1;
    bus.wr_gnt = 1'b0;
    bus.fifo_out = '0;
    bus.rd_data_count = 8'd5;
    repeat (3) step();
    chk("rst_wr_req", bus.wr_req, 0);
    chk("rst_fifo_rd", bus.fifo_rd, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_burst_cnt", bus.burst_cnt, 0);
    chk("rst_valid", bus.wr_data_valid, 0);
    chk("rst_done", bus.burst_done, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // ---- below-threshold counts never start a burst ----
    seen_req = 0; seen_rd = 0;
    for (int c = 5; c <= 7; c++) begin
      lvl = c;
      repeat (5) begin
        step();
        if (bus.wr_req === 1'b1) seen_req++;
        if (bus.fifo_rd === 1'b1) seen_rd++;
      end
    end
    chk("short_no_req", seen_req, 0);
    chk("short_no_rd", seen_rd, 0);
    chk("short_addr", bus.wr_addr, 0);

    // ---- table: five bursts, address wraps at 32 ----
    for (int v = 0; v < 5; v++) begin
      lvl = vecs[v].lvl;
      run_burst(vecs[v].gnt_dly, vecs[v].addr, vecs[v].word, vecs[v].cnt,
                vecs[v].next_addr, 1'b0);
    end

    // ---- enable dropped during XFER: burst still completes ----
    lvl = 8;
    run_burst(2, 24'd8, 32'h38, 16'd6, 24'd16, 1'b1);

    // ---- enable low: no request even with a deep FIFO; stray grant ignored ----
    lvl = 200;
    seen_req = 0; seen_rd = 0;
    for (int i = 0; i < 20; i++) begin
      bus.wr_gnt = (i == 5);
      step();
      if (bus.wr_req === 1'b1) seen_req++;
      if (bus.fifo_rd === 1'b1) seen_rd++;
    end
    bus.wr_gnt = 1'b0;
    chk("en_low_no_req", seen_req, 0);
    chk("stray_gnt_no_rd", seen_rd, 0);
    chk("en_low_idle", bus.busy, 0);

    // ---- enable falling in REQ does not withdraw the request ----
    enable = 1'b1;
    wait_req(10, ok);
    enable = 1'b0;
    run_burst(3, 24'd16, 32'h40, 16'd7, 24'd24, 1'b0);

    // ---- async reset at the 4th data word ----
    enable = 1'b1;
    wait_req(10, ok);
    bus.wr_gnt = 1'b1;
    step();
    bus.wr_gnt = 1'b0;
    n = 0; guard = 0;
    while (n < 4 && guard < 20) begin
      step();
      guard++;
      if (bus.wr_data_valid === 1'b1) n++;
    end
    chk("rst_mid_reach", n, 4);
    chk("rst_mid_word4", bus.wr_data, 32'h4B);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", bus.wr_req, 0);
    chk("rst_mid_rd", bus.fifo_rd, 0);
    chk("rst_mid_valid", bus.wr_data_valid, 0);
    chk("rst_mid_data", bus.wr_data, 0);
    chk("rst_mid_done", bus.burst_done, 0);
    chk("rst_mid_cnt", bus.burst_cnt, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_addr", bus.wr_addr, 0);
    lvl = 5;
    step();
    step();
    rst_n = 1'b1;
    seen_req = 0;
    repeat (10) begin
      step();
      if (bus.wr_req === 1'b1) seen_req++;
    end
    chk("post_rst_no_req", seen_req, 0);
    lvl = 8;
    run_burst(1, 24'd0, 32'h4C, 16'd1, 24'd8, 1'b0);

`ifdef FIFO_BURST_DRAIN_CHECK_EN
    // ---- data checker: 0..7 then 9..16 ----
    #1 rst_n = 1'b0;
    lvl = 0;
    step();
    step();
    chk("chk_rst_err", chk_err, 0);
    chk("chk_rst_cnt", chk_err_cnt, 0);
    word_next = 32'd0;
    skip_at = 32'd7;
    rst_n = 1'b1;
    lvl = 16;
    run_burst(1, 24'd0, 32'd0, 16'd1, 24'd8, 1'b0);
    chk("chk_clean_burst", chk_err, 0);
    run_burst(1, 24'd8, 32'd9, 16'd2, 24'd16, 1'b0);
    chk("chk_err_set", chk_err, 1);
    chk("chk_err_cnt", chk_err_cnt, 1);
    repeat (5) step();
    chk("chk_err_sticky", chk_err, 1);
    chk("chk_err_cnt_hold", chk_err_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
